// File: rtl/stream_demux2_if.sv
// Valid/ready bundle for stream_demux2: one source stream and two sink streams.
// The slave modport is the demultiplexer's view; master is the environment's view.
interface stream_demux2_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out1_data;

   modport slave (
      input  in_valid, in_data, in_sel, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out1_valid, out1_data
   );

   modport master (
      output in_valid, in_data, in_sel, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out1_valid, out1_data
   );
endinterface

// File: rtl/stream_demux2.sv
// Registered 1-to-2 stream demultiplexer with an independent 2-entry FIFO per sink.
// Optional per-sink push counters are enabled by defining STREAM_DEMUX2_STATS_EN.
module stream_demux2 #(
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   stream_demux2_if.slave      bus
`ifdef STREAM_DEMUX2_STATS_EN
   ,
   output logic [15:0]         out0_beats,
   output logic [15:0]         out1_beats
`endif
);

   logic [1:0]       cnt_r    [2];
   logic             wr_ptr_r [2];
   logic             rd_ptr_r [2];
   logic [WIDTH-1:0] mem_r    [2][2];

   logic [1:0]       push_s;
   logic [1:0]       pop_s;
   logic [1:0]       valid_s;
   logic             ready_s;

   // Handshake decode; ready looks only at the registered count of the selected FIFO.
   always_comb begin
      valid_s[0] = (cnt_r[0] != 2'd0);
      valid_s[1] = (cnt_r[1] != 2'd0);
      ready_s    = (cnt_r[bus.in_sel] != 2'd2);
      push_s[0]  = bus.in_valid & ready_s & ~bus.in_sel;
      push_s[1]  = bus.in_valid & ready_s &  bus.in_sel;
      pop_s[0]   = valid_s[0] & bus.out0_ready;
      pop_s[1]   = valid_s[1] & bus.out1_ready;
   end

   // Output drive: valid from count, data straight from the head entry.
   always_comb begin
      bus.in_ready   = ready_s;
      bus.out0_valid = valid_s[0];
      bus.out1_valid = valid_s[1];
      bus.out0_data  = mem_r[0][rd_ptr_r[0]];
      bus.out1_data  = mem_r[1][rd_ptr_r[1]];
   end

   // Pointer and count update; a simultaneous push and pop keeps the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            cnt_r[k]    <= 2'd0;
            wr_ptr_r[k] <= 1'b0;
            rd_ptr_r[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (push_s[k]) begin
               wr_ptr_r[k] <= ~wr_ptr_r[k];
            end else begin
               wr_ptr_r[k] <= wr_ptr_r[k];
            end
            if (pop_s[k]) begin
               rd_ptr_r[k] <= ~rd_ptr_r[k];
            end else begin
               rd_ptr_r[k] <= rd_ptr_r[k];
            end
            case ({push_s[k], pop_s[k]})
               2'b10:   cnt_r[k] <= cnt_r[k] + 2'd1;
               2'b01:   cnt_r[k] <= cnt_r[k] - 2'd1;
               default: cnt_r[k] <= cnt_r[k];
            endcase
         end
      end
   end

   // Payload storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (push_s[k]) begin
            mem_r[k][wr_ptr_r[k]] <= bus.in_data;
         end
      end
   end

`ifdef STREAM_DEMUX2_STATS_EN
   logic [15:0] beats_r [2];

   // Free-running push counters, wrapping at 16 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beats_r[0] <= 16'd0;
         beats_r[1] <= 16'd0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (push_s[k]) begin
               beats_r[k] <= beats_r[k] + 16'd1;
            end else begin
               beats_r[k] <= beats_r[k];
            end
         end
      end
   end

   assign out0_beats = beats_r[0];
   assign out1_beats = beats_r[1];
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Self-checking bench for stream_demux2: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the two output FIFOs.
module tb_stream_demux2;
   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic reset;
   stream_demux2_if #(.WIDTH(WIDTH)) bus ();
`ifdef STREAM_DEMUX2_STATS_EN
   logic [15:0] out0_beats;
   logic [15:0] out1_beats;
`endif

   stream_demux2 #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef STREAM_DEMUX2_STATS_EN
      ,
      .out0_beats (out0_beats),
      .out1_beats (out1_beats)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: each sink is an ordered queue holding at most two beats.
   logic [WIDTH-1:0] q0 [$];
   logic [WIDTH-1:0] q1 [$];
   logic [15:0]      pushes0;
   logic [15:0]      pushes1;
   bit               last_refused;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit model_ready(input bit sel);
      return sel ? (q1.size() != 2) : (q0.size() != 2);
   endfunction

   // Compare all meaningful DUT outputs against the model.
   task automatic compare();
      chk("in_ready", 32'(bus.in_ready), 32'(model_ready(bus.in_sel)));
      chk("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
      chk("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) chk("out0_data", bus.out0_data, q0[0]);
      if (q1.size() != 0) chk("out1_data", bus.out1_data, q1[0]);
`ifdef STREAM_DEMUX2_STATS_EN
      chk("out0_beats", 32'(out0_beats), 32'(pushes0));
      chk("out1_beats", 32'(out1_beats), 32'(pushes1));
`endif
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_update();
      bit rdy;
      bit pop0;
      bit pop1;
      rdy  = model_ready(bus.in_sel);
      pop0 = (q0.size() != 0) && bus.out0_ready;
      pop1 = (q1.size() != 0) && bus.out1_ready;
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (bus.in_valid && rdy) begin
         if (bus.in_sel) begin
            q1.push_back(bus.in_data);
            pushes1 = pushes1 + 16'd1;
         end else begin
            q0.push_back(bus.in_data);
            pushes0 = pushes0 + 16'd1;
         end
      end
      last_refused = bus.in_valid && !rdy;
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      pushes0 = 16'd0;
      pushes1 = 16'd0;
      last_refused = 1'b0;
   endtask

   // One cycle: drive, check on the falling edge, then step the model at the rising edge.
   task automatic step(input bit v, input bit sel, input logic [WIDTH-1:0] d,
                       input bit r0, input bit r1);
      bus.in_valid   = v;
      bus.in_sel     = sel;
      bus.in_data    = d;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
      @(negedge clk);
      compare();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid   = 1'b0;
      bus.in_sel     = 1'b0;
      bus.in_data    = '0;
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit               hv;
      bit               hsel;
      logic [WIDTH-1:0] hd;

      reset = 1'b1;
      idle_inputs();
      model_clear();
      do_reset();

      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
      chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
`ifdef STREAM_DEMUX2_STATS_EN
      chk("rst_out0_beats", 32'(out0_beats), 32'd0);
      chk("rst_out1_beats", 32'(out1_beats), 32'd0);
`endif

      // Streaming to out0 with the sink always ready.
      step(1'b1, 1'b0, 32'hA0, 1'b1, 1'b0);
      chk("a0_valid", 32'(bus.out0_valid), 32'd1);
      chk("a0_data", bus.out0_data, 32'hA0);
      step(1'b1, 1'b0, 32'hA1, 1'b1, 1'b0);
      chk("a1_data", bus.out0_data, 32'hA1);
      step(1'b1, 1'b0, 32'hA2, 1'b1, 1'b0);
      chk("a2_data", bus.out0_data, 32'hA2);
      chk("a_out1_idle", 32'(bus.out1_valid), 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("a_drained", 32'(bus.out0_valid), 32'd0);

      // Stalled out0 must not block out1.
      step(1'b1, 1'b0, 32'h10, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'b0;
      #1;
      chk("full0_ready", 32'(bus.in_ready), 32'd0);
      step(1'b1, 1'b0, 32'h12, 1'b1, 1'b0);
      chk("full_pop_refused", bus.out0_data, 32'h11);
      step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0);
      chk("b_out1_data", bus.out1_data, 32'h20);
      chk("b_out0_hold", bus.out0_data, 32'h11);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("b_out0_empty", 32'(bus.out0_valid), 32'd0);
      chk("b_out1_empty", 32'(bus.out1_valid), 32'd0);

      // Alternating destinations, both sinks ready: no bubbles.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, i[0], 32'hB0 + 32'(i), 1'b1, 1'b1);
         if (i[0]) chk("alt_out1", bus.out1_data, 32'hB0 + 32'(i));
         else      chk("alt_out0", bus.out0_data, 32'hB0 + 32'(i));
      end
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      // Asynchronous reset with out1 full.
      step(1'b1, 1'b1, 32'hC0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'hC1, 1'b0, 1'b0);
      idle_inputs();
      bus.in_sel = 1'b1;
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      chk("arst_out1_valid", 32'(bus.out1_valid), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_out1_valid", 32'(bus.out1_valid), 32'd0);
      step(1'b1, 1'b1, 32'hD0, 1'b0, 1'b1);
      chk("post_rst_first", bus.out1_data, 32'hD0);

      // Random traffic, source holds a refused beat.
      hv = 1'b0;
      hsel = 1'b0;
      hd = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!last_refused) begin
            hv   = ($urandom_range(0, 9) < 7);
            hsel = 1'($urandom_range(0, 1));
            hd   = $urandom;
         end
         step(hv, hsel, hd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      end

`ifdef STREAM_DEMUX2_STATS_EN
      do_reset();
      for (int i = 0; i < 65537; i++) begin
         step(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
      end
      chk("wrap_out0_beats", 32'(out0_beats), 32'd1);
      chk("wrap_out1_beats", 32'(out1_beats), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
